// File: rtl/aer_pkg.sv
// Shared AER definitions: broadcast prefix, dispatcher states and in_addr field split.
package aer_pkg;

  localparam logic [1:0] AER_BCAST_PREFIX = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    LINK_ACK
  } disp_state_e;

  // in_addr layout is {core_id, local_addr}; local_addr occupies the low local_w bits.
  function automatic logic [31:0] aer_core_id(input logic [31:0] addr, input int unsigned local_w);
    return addr >> local_w;
  endfunction

  function automatic logic [31:0] aer_local_addr(input logic [31:0] addr, input int unsigned local_w);
    return addr & ~({32{1'b1}} << local_w);
  endfunction

endpackage

// File: rtl/aer_core_event_dispatcher_decoder.sv
// Combinational target decode: broadcast detection and per-core target mask.
module aer_target_decoder #(
  parameter int unsigned CORE_NUM          = 4,
  parameter int unsigned AER_IN_CORE_WIDTH = 8,
  parameter int unsigned CORE_ID_WIDTH     = $clog2(CORE_NUM),
  parameter logic [1:0]  BCAST_PREFIX      = aer_pkg::AER_BCAST_PREFIX
) (
  input  logic [AER_IN_CORE_WIDTH-1:0] local_addr,
  input  logic [CORE_ID_WIDTH-1:0]     core_id,
  output logic [CORE_NUM-1:0]          mask,
  output logic                         is_bcast
);

  always_comb begin
    is_bcast = (local_addr[AER_IN_CORE_WIDTH-1 -: 2] == BCAST_PREFIX);
    mask     = is_bcast ? '1 : (CORE_NUM'(1) << core_id);
  end

endmodule

// File: rtl/aer_core_event_dispatcher.sv
// Accepts one link event at a time and fans it out to the addressed core(s)
// over per-core 4-phase handshakes sharing a single address bus.
module aer_core_event_dispatcher
  import aer_pkg::*;
#(
  parameter int unsigned CORE_NUM          = 4,
  parameter int unsigned AER_IN_CORE_WIDTH = 8,
  parameter int unsigned CORE_ID_WIDTH     = $clog2(CORE_NUM),
  parameter logic [1:0]  BCAST_PREFIX      = AER_BCAST_PREFIX
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_req,
  input  logic [CORE_ID_WIDTH+AER_IN_CORE_WIDTH-1:0] in_addr,
  output logic                                   in_ack,
  output logic [CORE_NUM-1:0]                    core_req,
  output logic [AER_IN_CORE_WIDTH-1:0]           core_addr,
  input  logic [CORE_NUM-1:0]                    core_ack,
  output logic                                   busy,
  output logic                                   proto_err,
  output logic [15:0]                            evt_cnt,
  output logic [15:0]                            bcast_cnt
);

  logic [CORE_ID_WIDTH-1:0]     in_core_id;
  logic [AER_IN_CORE_WIDTH-1:0] in_local;
  logic [CORE_NUM-1:0]          dec_mask;
  logic                         dec_bcast;

  disp_state_e                  state_q, state_d;
  logic                         in_ack_q, in_ack_d;
  logic [CORE_NUM-1:0]          core_req_q, core_req_d;
  logic [AER_IN_CORE_WIDTH-1:0] core_addr_q, core_addr_d;
  logic [CORE_NUM-1:0]          mask_q, mask_d;
  logic [CORE_NUM-1:0]          done_q, done_d;
  logic                         bcast_q, bcast_d;
  logic                         proto_err_q, proto_err_d;
  logic [15:0]                  evt_cnt_q, evt_cnt_d;
  logic [15:0]                  bcast_cnt_q, bcast_cnt_d;

  always_comb begin
    in_core_id = CORE_ID_WIDTH'(aer_core_id(32'(in_addr), AER_IN_CORE_WIDTH));
    in_local   = AER_IN_CORE_WIDTH'(aer_local_addr(32'(in_addr), AER_IN_CORE_WIDTH));
  end

  aer_target_decoder #(
    .CORE_NUM          (CORE_NUM),
    .AER_IN_CORE_WIDTH (AER_IN_CORE_WIDTH),
    .CORE_ID_WIDTH     (CORE_ID_WIDTH),
    .BCAST_PREFIX      (BCAST_PREFIX)
  ) u_decoder (
    .local_addr (in_local),
    .core_id    (in_core_id),
    .mask       (dec_mask),
    .is_bcast   (dec_bcast)
  );

  always_comb begin
    state_d     = state_q;
    in_ack_d    = in_ack_q;
    core_req_d  = core_req_q;
    core_addr_d = core_addr_q;
    mask_d      = mask_q;
    done_d      = done_q;
    bcast_d     = bcast_q;
    evt_cnt_d   = evt_cnt_q;
    bcast_cnt_d = bcast_cnt_q;
    // mask_q is cleared in IDLE, so any ack seen there is flagged as well.
    proto_err_d = proto_err_q | (|(core_ack & ~mask_q));

    unique case (state_q)
      IDLE: begin
        if (in_req && !in_ack_q) begin
          core_addr_d = in_local;
          mask_d      = dec_mask;
          core_req_d  = dec_mask;
          done_d      = '0;
          bcast_d     = dec_bcast;
          state_d     = DISPATCH;
        end
      end
      DISPATCH: begin
        core_req_d = core_req_q & ~(core_ack & mask_q);
        done_d     = done_q | (core_ack & mask_q);
        if (done_q == mask_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((core_ack & mask_q) == '0) begin
          in_ack_d = 1'b1;
          state_d  = LINK_ACK;
        end
      end
      LINK_ACK: begin
        if (!in_req) begin
          in_ack_d  = 1'b0;
          evt_cnt_d = evt_cnt_q + 16'd1;
          if (bcast_q) bcast_cnt_d = bcast_cnt_q + 16'd1;
          mask_d    = '0;
          done_d    = '0;
          bcast_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ack_q    <= 1'b0;
      core_req_q  <= '0;
      core_addr_q <= '0;
      mask_q      <= '0;
      done_q      <= '0;
      bcast_q     <= 1'b0;
      proto_err_q <= 1'b0;
      evt_cnt_q   <= '0;
      bcast_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ack_q    <= in_ack_d;
      core_req_q  <= core_req_d;
      core_addr_q <= core_addr_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      bcast_q     <= bcast_d;
      proto_err_q <= proto_err_d;
      evt_cnt_q   <= evt_cnt_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign core_req  = core_req_q;
  assign core_addr = core_addr_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;
  assign evt_cnt   = evt_cnt_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_aer_core_event_dispatcher.sv
// Directed plus randomized bench for aer_core_event_dispatcher with per-core responders.
module tb_aer_core_event_dispatcher;

  localparam int CN = 4;
  localparam int LW = 8;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_req;
  logic [IW-1:0] in_addr;
  logic          in_ack;
  logic [CN-1:0] core_req;
  logic [LW-1:0] core_addr;
  logic [CN-1:0] core_ack;
  logic          busy;
  logic          proto_err;
  logic [15:0]   evt_cnt;
  logic [15:0]   bcast_cnt;

  logic [CN-1:0] ack_r;
  logic [CN-1:0] spur;
  bit            comb_mode;
  int            dly[CN];
  int            cnt[CN];
  int            rx_cnt[CN] = '{default: 0};
  logic [LW-1:0] rx_addr[CN];
  int            rx_exp[CN] = '{default: 0};

  int            vectors = 0;
  int            miscompares = 0;
  int            exp_evt = 0;
  int            exp_bc = 0;
  logic          exp_perr = 1'b0;
  int            rt;

  always #5 clk = ~clk;

  // Core responders: either ack mirrors req (zero latency) or ack rises dly+1 edges after req.
  assign core_ack = (comb_mode ? core_req : ack_r) | spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= '0;
      for (int i = 0; i < CN; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < CN; i++) begin
        if (core_req[i] && !ack_r[i]) begin
          if (cnt[i] >= dly[i]) ack_r[i] <= 1'b1;
          else cnt[i] <= cnt[i] + 1;
        end else if (!core_req[i]) begin
          ack_r[i] <= 1'b0;
          cnt[i]   <= 0;
        end
      end
    end
  end

  // A core receives an event on the edge where its req and ack are both high.
  always @(posedge clk) begin
    for (int i = 0; i < CN; i++) begin
      if (core_req[i] && core_ack[i]) begin
        rx_cnt[i]  <= rx_cnt[i] + 1;
        rx_addr[i] <= core_addr;
      end
    end
  end

  aer_core_event_dispatcher #(
    .CORE_NUM          (CN),
    .AER_IN_CORE_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_addr   (in_addr),
    .in_ack    (in_ack),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_ack  (core_ack),
    .busy      (busy),
    .proto_err (proto_err),
    .evt_cnt   (evt_cnt),
    .bcast_cnt (bcast_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ack"}, in_ack, 0);
    chk({tag, "_core_req"}, core_req, 0);
    chk({tag, "_core_addr"}, core_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
    chk({tag, "_evt_cnt"}, evt_cnt, 0);
    chk({tag, "_bcast_cnt"}, bcast_cnt, 0);
  endtask

  // One full link transaction; spur_core >= 0 pulses that core's ack for one cycle.
  task automatic send(input logic [IW-1:0] a, input bit scramble, input int spur_core, output int rtrip);
    int            ai;
    int            loc;
    bit            bc;
    logic [CN-1:0] mask;
    logic [CN-1:0] pend;
    logic [CN-1:0] ackb;
    bit            got;
    ai    = int'(a);
    loc   = ai % 256;
    bc    = ((loc / 64) == 1);
    mask  = bc ? 4'hF : 4'(1 << (ai / 256));
    pend  = '0;
    got   = 1'b0;
    rtrip = 0;
    if (spur_core >= 0 && !mask[spur_core]) exp_perr = 1'b1;
    @(negedge clk);
    in_addr = a;
    in_req  = 1'b1;
    while (!got && rtrip < 200) begin
      ackb = core_ack;
      @(posedge clk);
      #1;
      rtrip++;
      if (rtrip == 1) begin
        pend = mask;
        chk("core_addr_latched", core_addr, loc);
        chk("busy_active", busy, 1);
      end else begin
        pend = pend & ~ackb;
      end
      chk("core_req", core_req, pend);
      if (in_ack) begin
        got = 1'b1;
        chk("targets_drained", core_ack & mask, 0);
      end
      @(negedge clk);
      if (scramble) in_addr = IW'($urandom);
      if (spur_core >= 0) spur = (rtrip == 1) ? 4'(1 << spur_core) : '0;
    end
    spur = '0;
    chk("in_ack_rise", got, 1);
    in_req = 1'b0;
    @(posedge clk);
    #1;
    exp_evt++;
    if (bc) exp_bc++;
    for (int i = 0; i < CN; i++) if (mask[i]) rx_exp[i]++;
    chk("in_ack_fall", in_ack, 0);
    chk("busy_idle", busy, 0);
    chk("evt_cnt", evt_cnt, 32'(exp_evt & 16'hFFFF));
    chk("bcast_cnt", bcast_cnt, 32'(exp_bc & 16'hFFFF));
    chk("proto_err", proto_err, exp_perr);
    for (int i = 0; i < CN; i++) begin
      chk($sformatf("rx_cnt%0d", i), rx_cnt[i], rx_exp[i]);
      if (mask[i]) chk($sformatf("rx_addr%0d", i), rx_addr[i], loc);
    end
  endtask

  initial begin
    logic [LW-1:0] loc;
    rst_n     = 1'b0;
    in_req    = 1'b0;
    in_addr   = '0;
    spur      = '0;
    comb_mode = 1'b1;
    for (int i = 0; i < CN; i++) dly[i] = 0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unicast, zero-latency cores: in_ack three edges after the sampling edge.
    send(10'h215, 1'b0, -1, rt);
    chk("round_trip", rt, 4);

    // Broadcast with staggered acks at +1,+4,+2,+7.
    comb_mode = 1'b0;
    dly = '{0, 3, 1, 6};
    send(10'h141, 1'b0, -1, rt);

    // Prefix boundary neighbours stay unicast.
    dly = '{0, 0, 0, 0};
    send(10'h381, 1'b0, -1, rt);
    send(10'h0C0, 1'b0, -1, rt);

    // Spurious ack on core 3 during a unicast to core 1.
    dly[1] = 3;
    send(10'h123, 1'b0, 3, rt);

    // Back-to-back unicasts with in_addr scrambled while busy.
    for (int k = 0; k < 8; k++) begin
      loc = LW'($urandom_range(0, 255));
      if (loc[7:6] == 2'b01) loc[7] = 1'b1;
      send({2'(k % 4), loc}, 1'b1, -1, rt);
    end

    // Random traffic, random responder latency.
    for (int k = 0; k < 40; k++) begin
      comb_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < CN; i++) dly[i] = $urandom_range(0, 5);
      send(IW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), -1, rt);
    end

    // Asynchronous reset in the middle of a broadcast dispatch.
    comb_mode = 1'b0;
    dly = '{50, 50, 50, 50};
    @(negedge clk);
    in_addr = 10'h141;
    in_req  = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_core_req", core_req, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    in_req   = 1'b0;
    exp_evt  = 0;
    exp_bc   = 0;
    exp_perr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dly = '{0, 0, 0, 0};
    send(10'h2AA, 1'b0, -1, rt);
    send(10'h07F, 1'b0, -1, rt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
